// File: rtl/lsu_dmem.sv
// -----------------------------------------------------------------------------
// lsu_dmem -- load/store unit between the single-cycle datapath and a
// handshaked data-memory bus.
//
// A load or store presented in IDLE is checked for alignment. Aligned accesses
// are latched into word-aligned bus request fields and the core is stalled
// until the bus acknowledges. The extended load result is returned with a
// one-cycle rdata_valid pulse in DONE. Misaligned accesses raise misalign_err
// for that cycle and retire without touching the bus.
//
// Optional feature macro: LSU_TIMEOUT_EN
//   Defined  : a REQ that sees no bus_ack within TIMEOUT_CYC cycles is aborted.
//              bus_err pulses and a load returns 32'hDEADBEEF.
//   Undefined: REQ waits indefinitely and bus_err is constant 0.
//
// Handshake: bus_req is held high together with stable bus_we/bus_addr/
// bus_be/bus_wdata from the first REQ cycle until the cycle in which bus_ack
// is sampled high. bus_rdata is taken in that same cycle. bus_req is low from
// the following edge. bus_ack outside REQ is ignored.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid           current instruction is a load or store
//   req_we              1 = store, 0 = load
//   req_wdin_op [1:0]   0 sb, 1 sh, 2/3 sw
//   req_rb_op   [2:0]   0 lb, 1 lbu, 2 lh, 3 lhu, 4-7 lw
//   req_addr    [31:0]  byte address
//   req_wdata   [31:0]  store data
//   stall               hold PC and register-file write (combinational)
//   rdata       [31:0]  extended load result, held until the next load
//   rdata_valid         one-cycle pulse in DONE for loads
//   misalign_err        misaligned access rejected (combinational)
//   bus_req/we/addr/be/wdata  registered bus request
//   bus_ack, bus_rdata  bus completion and read word
//   bus_err             timeout abort pulse
//   dbg_state   [1:0]   FSM state: 0 IDLE, 1 REQ, 2 DONE
// -----------------------------------------------------------------------------
module lsu_dmem #(
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [1:0]  req_wdin_op,
   input  logic [2:0]  req_rb_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        misalign_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic        bus_err,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next_state;

   logic        w_misalign;
   logic        w_start;
   logic        w_ack_done;
   logic        w_abort;
   logic        w_timeout;
   logic [3:0]  w_st_be;
   logic [31:0] w_st_wdata;
   logic [7:0]  w_ld_byte;
   logic [15:0] w_ld_half;
   logic [31:0] w_ld_data;

   logic        r_bus_req;
   logic        r_bus_we;
   logic [31:0] r_bus_addr;
   logic [3:0]  r_bus_be;
   logic [31:0] r_bus_wdata;
   logic [1:0]  r_off;
   logic [2:0]  r_rb_op;
   logic [31:0] r_rdata;
   logic        r_rdata_valid;

   // Alignment: byte accesses never fault, halfwords need addr[0]=0,
   // words need addr[1:0]=0.
   always_comb begin
      w_misalign = 1'b0;
      if (req_we) begin
         case (req_wdin_op)
            2'd0:    w_misalign = 1'b0;
            2'd1:    w_misalign = req_addr[0];
            default: w_misalign = |req_addr[1:0];
         endcase
      end else begin
         case (req_rb_op)
            3'd0, 3'd1: w_misalign = 1'b0;
            3'd2, 3'd3: w_misalign = req_addr[0];
            default:    w_misalign = |req_addr[1:0];
         endcase
      end
   end

   // Store lane placement: narrow data is replicated across the word so the
   // byte enables alone select the target lanes.
   always_comb begin
      w_st_be    = 4'b1111;
      w_st_wdata = req_wdata;
      case (req_wdin_op)
         2'd0: begin
            w_st_be    = 4'b0001 << req_addr[1:0];
            w_st_wdata = {4{req_wdata[7:0]}};
         end
         2'd1: begin
            w_st_be    = req_addr[1] ? 4'b1100 : 4'b0011;
            w_st_wdata = {2{req_wdata[15:0]}};
         end
         default: begin
            w_st_be    = 4'b1111;
            w_st_wdata = req_wdata;
         end
      endcase
   end

   // Load extraction uses the offset and op latched at request time.
   always_comb begin
      w_ld_byte = bus_rdata[7:0];
      case (r_off)
         2'd0: w_ld_byte = bus_rdata[7:0];
         2'd1: w_ld_byte = bus_rdata[15:8];
         2'd2: w_ld_byte = bus_rdata[23:16];
         2'd3: w_ld_byte = bus_rdata[31:24];
         default: w_ld_byte = bus_rdata[7:0];
      endcase
      w_ld_half = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (r_rb_op)
         3'd0:    w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
         3'd1:    w_ld_data = {24'd0, w_ld_byte};
         3'd2:    w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
         3'd3:    w_ld_data = {16'd0, w_ld_half};
         default: w_ld_data = bus_rdata;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next state and combinational outputs
   always_comb begin
      w_next_state = r_state;
      stall        = 1'b0;
      misalign_err = 1'b0;
      w_start      = 1'b0;
      w_ack_done   = 1'b0;
      w_abort      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               if (w_misalign) begin
                  // Rejected access retires immediately: no stall.
                  misalign_err = 1'b1;
               end else begin
                  stall        = 1'b1;
                  w_start      = 1'b1;
                  w_next_state = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            stall = 1'b1;
            // An ack in the last counted cycle takes priority over the abort.
            if (bus_ack) begin
               w_ack_done   = 1'b1;
               w_next_state = ST_DONE;
            end else if (w_timeout) begin
               w_abort      = 1'b1;
               w_next_state = ST_DONE;
            end
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Bus request fields and load result
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bus_req     <= 1'b0;
         r_bus_we      <= 1'b0;
         r_bus_addr    <= 32'd0;
         r_bus_be      <= 4'd0;
         r_bus_wdata   <= 32'd0;
         r_off         <= 2'd0;
         r_rb_op       <= 3'd0;
         r_rdata       <= 32'd0;
         r_rdata_valid <= 1'b0;
      end else begin
         r_rdata_valid <= 1'b0;
         if (w_start) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= req_we;
            r_bus_addr  <= {req_addr[31:2], 2'b00};
            r_off       <= req_addr[1:0];
            r_rb_op     <= req_rb_op;
            r_bus_be    <= req_we ? w_st_be : 4'b1111;
            r_bus_wdata <= req_we ? w_st_wdata : 32'd0;
         end
         if (w_ack_done) begin
            r_bus_req <= 1'b0;
            if (!r_bus_we) begin
               r_rdata       <= w_ld_data;
               r_rdata_valid <= 1'b1;
            end
         end
         if (w_abort) begin
            r_bus_req <= 1'b0;
            if (!r_bus_we) begin
               r_rdata       <= 32'hDEAD_BEEF;
               r_rdata_valid <= 1'b1;
            end
         end
      end
   end

`ifdef LSU_TIMEOUT_EN
   localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_bus_err;

   // r_cnt holds the number of REQ cycles already completed, so it equals
   // CNT_LAST during the final allowed REQ cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_bus_err <= 1'b0;
      end else begin
         r_bus_err <= w_abort;
         if (w_start) begin
            r_cnt <= '0;
         end else if (r_state == ST_REQ) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign w_timeout = (r_cnt == CNT_LAST);
   assign bus_err   = r_bus_err;
`else
   assign w_timeout = 1'b0;
   // Constant 0; the parameter is referenced so both builds share one interface.
   assign bus_err   = (TIMEOUT_CYC == 0) ? 1'b0 : 1'b0;
`endif

   assign bus_req     = r_bus_req;
   assign bus_we      = r_bus_we;
   assign bus_addr    = r_bus_addr;
   assign bus_be      = r_bus_be;
   assign bus_wdata   = r_bus_wdata;
   assign rdata       = r_rdata;
   assign rdata_valid = r_rdata_valid;
   assign dbg_state   = r_state;

endmodule

// File: doc/lsu_dmem.md
Name: lsu_dmem

Overview:
- Load/store unit between the single-cycle datapath and a handshaked data-memory bus.
- Consumes the decoder's memory controls (ram_we, ram_wdin_op, ram_rb_op), the ALU address and the rs2 store data.
- Drives word-aligned bus requests with byte enables and returns a sign/zero-extended load result for write-back.
- Stalls the core (PC and register-file write held) while a bus transaction is outstanding.

Parameters:
- TIMEOUT_CYC, 16, maximum REQ-state cycles before abort. Used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset. Synchronous, active-low.
- req_valid  in  1  current instruction is a load or store.
- req_we  in  1  1 = store, 0 = load (ram_we).
- req_wdin_op  in  2  0 sb, 1 sh, 2 sw, 3 treated as sw.
- req_rb_op  in  3  0 lb, 1 lbu, 2 lh, 3 lhu, 4 lw, 5-7 treated as lw.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (rs2).
- stall  out  1  hold PC and rf_we this cycle.
- rdata  out  32  extended load result.
- rdata_valid  out  1  one-cycle pulse: rdata is valid for write-back.
- misalign_err  out  1  misaligned access rejected.
- bus_req  out  1  request strobe.
- bus_we  out  1  bus write.
- bus_addr  out  32  word address, {req_addr[31:2], 2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_ack  in  1  transaction complete; bus_rdata valid in the same cycle.
- bus_rdata  in  32  read word.
- bus_err  out  1  timeout abort pulse. Tied 0 without LSU_TIMEOUT_EN.

Behaviour:
- Reset: rst_n sampled low at a clock edge sets state to IDLE. All registered outputs go to 0: bus_req, bus_we, bus_addr, bus_be, bus_wdata, rdata, rdata_valid, bus_err.
  - Combinational stall and misalign_err are 0 while state is IDLE and req_valid is 0.
  - Reset during REQ abandons the transaction. bus_req is 0 from the next cycle; a late bus_ack is ignored.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - req_valid with an aligned address: latch we, op, addr[1:0], bus_addr, bus_be and bus_wdata; next state REQ; stall=1 combinationally in this cycle.
  - req_valid with a misaligned address: misalign_err=1 and stall=0 combinationally. No bus activity, no state change, and the instruction retires. rdata is not updated.
- Misalignment rules:
  - sh, lh and lhu require addr[0]=0.
  - sw and lw require addr[1:0]=0.
  - Byte accesses are never misaligned.
- REQ:
  - bus_req=1 and stall=1; the request fields stay stable until bus_ack.
  - On bus_ack: bus_req=0 at the next edge, next state DONE. For loads, rdata is registered from the extracted bus_rdata.
- DONE (one cycle):
  - stall=0, rdata_valid=1 for loads only, so the core retires the instruction.
  - req_valid is ignored; next state is IDLE.
- Latency:
  - Minimum 3 cycles (IDLE, REQ with ack, DONE).
  - Each extra REQ cycle adds 1.
  - Back-to-back memory instructions re-enter REQ from the IDLE cycle that follows DONE.
- Store lanes (o = addr[1:0]):
  - sb: be = 1 << o, wdata = {4{req_wdata[7:0]}}.
  - sh: be = o[1] ? 4'b1100 : 4'b0011, wdata = {2{req_wdata[15:0]}}.
  - sw: be = 4'b1111, wdata = req_wdata.
- Loads:
  - bus_be = 4'b1111 and bus_wdata = 0 on the bus.
  - Byte selected by o; halfword selected by o[1].
  - lb and lh sign-extend; lbu and lhu zero-extend; lw passes the word through.
- Hold: rdata holds its value until the next load completes.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- With the macro defined:
  - A counter clears on REQ entry and increments each REQ cycle.
  - If TIMEOUT_CYC cycles elapse without bus_ack: bus_req drops, bus_err pulses for 1 cycle, and the FSM goes to DONE.
  - A load aborted this way returns rdata=32'hDEADBEEF with rdata_valid=1.
  - bus_ack arriving in the final counted cycle wins over the timeout.
- Without the macro: no counter; REQ waits indefinitely and bus_err is constant 0.

Test Plan:
- lb at addr 0x1003, bus_rdata=0x80FF_1234, ack in the first REQ cycle -> bus_addr=0x1000, be=4'hF; rdata=0xFFFF_FF80 in DONE with a rdata_valid pulse; stall high for exactly 2 cycles.
- sh at addr 0x2002, rs2=0xAAAA_5678, ack after 3 REQ cycles -> be=4'b1100, wdata=0x5678_5678; stall high for 4 cycles; rdata_valid stays 0.
- lw at addr 0x3001 -> misalign_err=1 and stall=0 in the same cycle; bus_req never asserts; rdata unchanged.
- lhu at 0x4002, bus_rdata=0xBEEF_0001; then lh at 0x4002 with the same data -> rdata=0x0000_BEEF, then 0xFFFF_BEEF.
- Load in REQ, rst_n low for 1 edge, then bus_ack asserted -> state IDLE; bus_req=0 and all registered outputs 0 after the edge; the late ack is ignored.
- With LSU_TIMEOUT_EN, TIMEOUT_CYC=16, bus_ack held 0 -> bus_err pulses after 16 REQ cycles; rdata=0xDEADBEEF with rdata_valid=1 in DONE; state back to IDLE.
